// File: rtl/weight_feeder_pkg.sv
// ----------------------------------------------------------------------------
// weight_feeder_pkg
// Shared definitions for the weight feeder: default sizing, counter widths,
// FSM state codes (also exported on status_wfeed) and the per-job beat total
// helper.
// Weights occupy the low DATA_WEIGHT_WIDTH (8) bits of each 16-bit lane; the
// feeder never looks inside a lane, so no constant is carried for it here.
// No ports (package).
// ----------------------------------------------------------------------------
package weight_feeder_pkg;

    localparam int CONV_GROUP_NUM_DEF = 64;   // weights per group, multiple of 8, max 64
    localparam int DCNT_HIGH_DEF      = 480;  // mux FIFO level that stops new beat loads
    localparam int BEAT_CNT_W         = 27;   // 24-bit N times up to 8 beats per group
    localparam int WORD_CNT_W         = 28;   // two 64-bit words per beat

    typedef enum logic [3:0] {
        WFEED_IDLE     = 4'd0,
        WFEED_CFG_SEND = 4'd1,
        WFEED_STREAM   = 4'd2,
        WFEED_DONE     = 4'd3
    } wfeed_state_t;

    // N = 0 still runs one group so the mux and the feeder agree on length.
    function automatic logic [BEAT_CNT_W-1:0] calc_total(
        input logic [23:0]           n,
        input logic [BEAT_CNT_W-1:0] bpg
    );
        logic [BEAT_CNT_W-1:0] groups;
        groups = (n == 24'd0) ? BEAT_CNT_W'(1) : BEAT_CNT_W'(n);
        return groups * bpg;
    endfunction

endpackage

// File: rtl/weight_feeder_pack.sv
// ----------------------------------------------------------------------------
// weight_feeder_pack
// Packs pairs of 64-bit words into 128-bit beats: the even word waits in a
// half register, the odd word completes the beat into a single output slot.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_clear        drop any held half word / beat (new job)
//   i_word_vld     a word is accepted this cycle
//   i_word         64-bit word
//   i_load_en      downstream has room for another beat (throttle)
//   i_ready        downstream ready for the slot
//   o_valid        slot holds a beat
//   o_beat         {even word, odd word}
//   o_half_full    half register holds an even word
//   o_slot_open    slot can take a new beat on this edge
// ----------------------------------------------------------------------------
module weight_feeder_pack (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_word_vld,
    input  logic [63:0]  i_word,
    input  logic         i_load_en,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [127:0] o_beat,
    output logic         o_half_full,
    output logic         o_slot_open
);

    logic [63:0]  r_half;
    logic         r_half_full;
    logic         r_valid;
    logic [127:0] r_beat;
    logic         w_slot_open;
    logic         w_load;

    // The throttle only gates loading; a beat already in the slot stays valid.
    assign w_slot_open = (~r_valid | i_ready) & i_load_en;
    assign w_load      = i_word_vld & r_half_full & w_slot_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half      <= '0;
            r_half_full <= 1'b0;
            r_valid     <= 1'b0;
            r_beat      <= '0;
        end else if (i_clear) begin
            r_half_full <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (r_valid && i_ready)
                r_valid <= 1'b0;
            // A reload on the handshake edge overrides the clear: no bubble.
            if (w_load) begin
                r_beat      <= {r_half, i_word};
                r_valid     <= 1'b1;
                r_half_full <= 1'b0;
            end else if (i_word_vld && !r_half_full) begin
                r_half      <= i_word;
                r_half_full <= 1'b1;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_beat      = r_beat;
    assign o_half_full = r_half_full;
    assign o_slot_open = w_slot_open;

endmodule

// File: rtl/weight_feeder.sv
// ----------------------------------------------------------------------------
// weight_feeder
// Source end of the 128-bit weight stream into the weight distribution mux.
// Takes one job config (N groups), forwards it to the mux, then streams
// exactly max(N,1)*BEATS_PER_GROUP packed beats, throttled by weight_dcnt.
// Ports:
//   s_cfg_*         job config in ([23:0] = N)
//   m_config_*      config out to mux, {8'd0, N}
//   s_axis_*        64-bit DMA weight words (tlast checked only under macro)
//   m_weight*       128-bit packed beats
//   weight_dcnt     mux FIFO fill level
//   busy / done     job in flight / one-cycle end-of-job pulse
//   status_wfeed    current state code
//   err_tlast       only with WFEED_TLAST_CHECK_EN: sticky tlast misplacement
// Optional build macro: WFEED_TLAST_CHECK_EN
//
// state          | meaning
// WFEED_IDLE     | waiting for job config, s_cfg_ready high
// WFEED_CFG_SEND | presenting latched config to the mux
// WFEED_STREAM   | accepting words and emitting beats
// WFEED_DONE     | one-cycle done pulse, then back to idle
// ----------------------------------------------------------------------------
module weight_feeder
    import weight_feeder_pkg::*;
#(
    parameter int CONV_GROUP_NUM = CONV_GROUP_NUM_DEF,
    parameter int DCNT_HIGH      = DCNT_HIGH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_cfg_valid,
    output logic         s_cfg_ready,
    input  logic [31:0]  s_cfg_data,
    output logic         m_config_valid,
    input  logic         m_config_ready,
    output logic [31:0]  m_config_data,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [63:0]  s_axis_tdata,
    input  logic         s_axis_tlast,
    output logic         m_weight_valid,
    input  logic         m_weight_ready,
    output logic [127:0] m_weight,
    input  logic [9:0]   weight_dcnt,
    output logic         busy,
    output logic         done,
    output logic [3:0]   status_wfeed
`ifdef WFEED_TLAST_CHECK_EN
    ,
    output logic         err_tlast
`endif
);

    localparam int             BEATS_PER_GROUP = CONV_GROUP_NUM / 8;
    localparam logic [9:0]     DCNT_HIGH_W     = 10'(DCNT_HIGH);

    wfeed_state_t           r_state;
    wfeed_state_t           w_state_nxt;
    logic [23:0]            r_n;
    logic [BEAT_CNT_W-1:0]  r_total;
    logic [BEAT_CNT_W-1:0]  r_beat_cnt;
    logic [WORD_CNT_W-1:0]  r_word_cnt;
    logic [WORD_CNT_W-1:0]  w_word_total;
    logic                   w_cfg_hs;
    logic                   w_beat_hs;
    logic                   w_word_hs;
    logic                   w_last_beat;
    logic                   w_words_left;
    logic                   w_half_full;
    logic                   w_slot_open;
    logic                   w_load_en;

    assign w_word_total = {r_total, 1'b0};
    assign w_load_en    = (weight_dcnt < DCNT_HIGH_W);
    assign w_cfg_hs     = s_cfg_valid & s_cfg_ready;
    assign w_beat_hs    = m_weight_valid & m_weight_ready;
    assign w_word_hs    = s_axis_tvalid & s_axis_tready;
    assign w_last_beat  = (r_beat_cnt == r_total - BEAT_CNT_W'(1));
    assign w_words_left = (r_word_cnt < w_word_total);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= WFEED_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WFEED_IDLE:     if (w_cfg_hs) w_state_nxt = WFEED_CFG_SEND;
            WFEED_CFG_SEND: if (m_config_ready) w_state_nxt = WFEED_STREAM;
            WFEED_STREAM:   if (w_beat_hs && w_last_beat) w_state_nxt = WFEED_DONE;
            WFEED_DONE:     w_state_nxt = WFEED_IDLE;
            default:        w_state_nxt = WFEED_IDLE;
        endcase
    end

    always_comb begin
        s_cfg_ready    = (r_state == WFEED_IDLE);
        m_config_valid = (r_state == WFEED_CFG_SEND);
        busy           = (r_state != WFEED_IDLE);
        done           = (r_state == WFEED_DONE);
        status_wfeed   = r_state;
        // Word budget caps intake at 2*TOTAL; surplus DMA words wait for the next job.
        s_axis_tready  = (r_state == WFEED_STREAM) & w_words_left
                         & (~w_half_full | w_slot_open);
    end

    assign m_config_data = {8'd0, r_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_total    <= '0;
            r_beat_cnt <= '0;
            r_word_cnt <= '0;
        end else if (w_cfg_hs) begin
            r_n        <= s_cfg_data[23:0];
            r_total    <= calc_total(s_cfg_data[23:0], BEAT_CNT_W'(BEATS_PER_GROUP));
            r_beat_cnt <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_beat_hs)
                r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            if (w_word_hs)
                r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
        end
    end

    weight_feeder_pack u_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_cfg_hs),
        .i_word_vld  (w_word_hs),
        .i_word      (s_axis_tdata),
        .i_load_en   (w_load_en),
        .i_ready     (m_weight_ready),
        .o_valid     (m_weight_valid),
        .o_beat      (m_weight),
        .o_half_full (w_half_full),
        .o_slot_open (w_slot_open)
    );

`ifdef WFEED_TLAST_CHECK_EN
    logic r_err_tlast;
    logic w_tlast_exp;
    logic w_unused_in;

    assign w_tlast_exp = (r_word_cnt == w_word_total - WORD_CNT_W'(1));
    assign w_unused_in = ^s_cfg_data[31:24];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_tlast <= 1'b0;
        else if (w_cfg_hs)
            r_err_tlast <= 1'b0;
        else if (w_word_hs && (s_axis_tlast != w_tlast_exp))
            r_err_tlast <= 1'b1;
    end

    assign err_tlast = r_err_tlast;
`else
    logic w_unused_in;
    assign w_unused_in = ^{s_cfg_data[31:24], s_axis_tlast};
`endif

endmodule
